// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl
//   Turns two raw push-buttons into the duty value that the PWM counter compares
//   against. Each button is synchronised (2 flops), debounced, and edge-detected.
//   A clean press steps a target duty up or down by STEP, saturating at 0 and MAX.
//   The target is copied to oDuty only on an iPeriodEnd pulse, so a running PWM
//   period is never cut short.
//
// Ports
//   iClk        in   system clock, rising edge
//   iRst_n      in   asynchronous active-low reset
//   iBtnUp      in   raw async button, 1 = pressed
//   iBtnDown    in   raw async button, 1 = pressed
//   iPeriodEnd  in   1-cycle pulse when the PWM count wraps to 0
//   oDuty       out  applied duty 0..MAX
//   oUpdate     out  1-cycle pulse on the cycle oDuty takes a new value
//   oAtMax      out  oDuty == MAX
//   oAtMin      out  oDuty == 0
module pwm_duty_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int CW         = 16,
    parameter int STEP       = 25,
    parameter int MAX        = 100,
    parameter int INIT       = 0
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iBtnUp,
    input  logic       iBtnDown,
    input  logic       iPeriodEnd,
    output logic [6:0] oDuty,
    output logic       oUpdate,
    output logic       oAtMax,
    output logic       oAtMin
);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [6:0]    MAX_W    = 7'(MAX);
    localparam logic [6:0]    STEP_W   = 7'(STEP);
    localparam logic [6:0]    INIT_W   = 7'(INIT);

    // Bit 0 = up button, bit 1 = down button
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_q;
    logic [CW-1:0] cnt [2];

    logic [1:0]    press;
    logic          up_ev;
    logic          dn_ev;

    logic [6:0]    target;
    logic [6:0]    target_nxt;
    logic [6:0]    duty;
    logic          upd;

    assign raw = {iBtnDown, iBtnUp};

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < 2; i++) begin
                // Any sample agreeing with the accepted level restarts the run,
                // so only DEB_CYCLES consecutive mismatches flip the level.
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb & ~deb_q;
    assign up_ev = press[0] & ~press[1];
    assign dn_ev = press[1] & ~press[0];

    // Saturation tests are done in int so target + STEP can never wrap 7 bits.
    always_comb begin
        target_nxt = target;
        if (up_ev) begin
            target_nxt = (MAX - int'(target) < STEP) ? MAX_W : target + STEP_W;
        end else if (dn_ev) begin
            target_nxt = (int'(target) < STEP) ? 7'd0 : target - STEP_W;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            target <= INIT_W;
            duty   <= INIT_W;
            upd    <= 1'b0;
        end else begin
            target <= target_nxt;
            // Uses the registered target, so a press landing on the boundary
            // cycle waits for the next boundary.
            if (iPeriodEnd && (target != duty)) begin
                duty <= target;
                upd  <= 1'b1;
            end else begin
                upd  <= 1'b0;
            end
        end
    end

    assign oDuty   = duty;
    assign oUpdate = upd;
    assign oAtMax  = (duty == MAX_W);
    assign oAtMin  = (duty == 7'd0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
module tb_pwm_duty_ctrl;

    localparam int DEB  = 4;
    localparam int STEP = 25;
    localparam int MAX  = 100;
    localparam int INIT = 0;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iBtnUp = 1'b0;
    logic       iBtnDown = 1'b0;
    logic       iPeriodEnd = 1'b0;
    logic [6:0] oDuty;
    logic       oUpdate;
    logic       oAtMax;
    logic       oAtMin;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_duty_ctrl #(
        .DEB_CYCLES(DEB),
        .CW(4),
        .STEP(STEP),
        .MAX(MAX),
        .INIT(INIT)
    ) dut (
        .iClk(iClk),
        .iRst_n(iRst_n),
        .iBtnUp(iBtnUp),
        .iBtnDown(iBtnDown),
        .iPeriodEnd(iPeriodEnd),
        .oDuty(oDuty),
        .oUpdate(oUpdate),
        .oAtMax(oAtMax),
        .oAtMin(oAtMin)
    );

    always #5 iClk = ~iClk;

    // Reference model: raw-sample history per button; a button's accepted
    // level flips once the DEB samples seen by the filter all disagree with it.
    bit hu[$];
    bit hd[$];
    bit m_deb_up, m_deb_dn, m_prev_up, m_prev_dn;
    int m_target, m_duty;
    bit m_upd;

    function automatic bit all_differ(input bit q[$], input bit lvl);
        bit r = 1'b1;
        // q[DEB+1] is the newest raw sample; the filter sees samples two edges old
        for (int k = 0; k < DEB; k++) begin
            if (q[k] == lvl) r = 1'b0;
        end
        return r;
    endfunction

    function automatic void model_reset();
        hu = {};
        hd = {};
        for (int k = 0; k < DEB + 2; k++) begin
            hu.push_back(1'b0);
            hd.push_back(1'b0);
        end
        m_deb_up = 0; m_deb_dn = 0; m_prev_up = 0; m_prev_dn = 0;
        m_target = INIT; m_duty = INIT; m_upd = 0;
    endfunction

    function automatic void model_step();
        bit ev_up, ev_dn;
        ev_up = m_deb_up && !m_prev_up;
        ev_dn = m_deb_dn && !m_prev_dn;
        if (iPeriodEnd && m_target != m_duty) begin
            m_duty = m_target;
            m_upd  = 1;
        end else begin
            m_upd  = 0;
        end
        if (ev_up && !ev_dn) m_target = (m_target + STEP > MAX) ? MAX : m_target + STEP;
        else if (ev_dn && !ev_up) m_target = (m_target < STEP) ? 0 : m_target - STEP;
        m_prev_up = m_deb_up;
        m_prev_dn = m_deb_dn;
        hu.push_back(iBtnUp);   void'(hu.pop_front());
        hd.push_back(iBtnDown); void'(hd.pop_front());
        if (all_differ(hu, m_deb_up)) m_deb_up = !m_deb_up;
        if (all_differ(hd, m_deb_dn)) m_deb_dn = !m_deb_dn;
    endfunction

    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) model_reset();
        else         model_step();
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_model();
        chk("model_duty",   int'(oDuty),   m_duty);
        chk("model_update", int'(oUpdate), int'(m_upd));
        chk("model_atmax",  int'(oAtMax),  int'(m_duty == MAX));
        chk("model_atmin",  int'(oAtMin),  int'(m_duty == 0));
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
            check_model();
        end
    endtask

    task automatic do_reset();
        iRst_n = 1'b0;
        iBtnUp = 0; iBtnDown = 0; iPeriodEnd = 0;
        step(2);
        iRst_n = 1'b1;
        step(2);
    endtask

    task automatic press_up();
        iBtnUp = 1; step(8);
        iBtnUp = 0; step(8);
    endtask

    task automatic press_dn();
        iBtnDown = 1; step(8);
        iBtnDown = 0; step(8);
    endtask

    task automatic boundary(input string name, input int exp_duty, input bit exp_upd);
        iPeriodEnd = 1; step(1);
        chk({name, "_duty"}, int'(oDuty), exp_duty);
        chk({name, "_upd"},  int'(oUpdate), int'(exp_upd));
        iPeriodEnd = 0; step(1);
        chk({name, "_upd_off"}, int'(oUpdate), 0);
    endtask

    typedef struct {
        bit up;
        bit dn;
        bit pe;
        int cyc;
        int exp_duty;
        bit exp_upd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int prev, nxt;
        model_reset();

        // Table: five up presses separated by releases and boundaries
        for (int p = 0; p < 5; p++) begin
            prev = (25 * p > 100) ? 100 : 25 * p;
            nxt  = (25 * (p + 1) > 100) ? 100 : 25 * (p + 1);
            tbl.push_back('{1, 0, 0, 8, prev, 0});
            tbl.push_back('{0, 0, 0, 8, prev, 0});
            tbl.push_back('{0, 0, 1, 1, nxt, p < 4});
            tbl.push_back('{0, 0, 0, 1, nxt, 0});
        end

        // Reset state
        iRst_n = 0;
        step(3);
        chk("rst_duty", int'(oDuty), 0);
        chk("rst_upd", int'(oUpdate), 0);
        chk("rst_atmin", int'(oAtMin), 1);
        chk("rst_atmax", int'(oAtMax), 0);
        iRst_n = 1;
        step(2);

        // Press latency: raw rises before edge N, target moves at N+6,
        // with iPeriodEnd held the duty follows at N+7
        iBtnUp = 1; iPeriodEnd = 1;
        for (int e = 0; e < 7; e++) begin
            step(1);
            chk("lat_hold_duty", int'(oDuty), 0);
        end
        step(1);
        chk("lat_duty", int'(oDuty), 25);
        chk("lat_upd", int'(oUpdate), 1);
        iPeriodEnd = 0;
        step(2);
        chk("lat_upd_once", int'(oUpdate), 0);
        iBtnUp = 0;
        step(8);

        // Table-driven saturation sequence
        do_reset();
        foreach (tbl[i]) begin
            iBtnUp = tbl[i].up; iBtnDown = tbl[i].dn; iPeriodEnd = tbl[i].pe;
            step(tbl[i].cyc);
            chk("tbl_duty", int'(oDuty), tbl[i].exp_duty);
            chk("tbl_upd", int'(oUpdate), int'(tbl[i].exp_upd));
        end
        iPeriodEnd = 0;
        chk("tbl_atmax", int'(oAtMax), 1);

        // Short glitch is filtered; down at 0 saturates
        do_reset();
        iBtnUp = 1; step(2);
        iBtnUp = 0; step(8);
        boundary("glitch", 0, 0);
        press_dn();
        boundary("down_at_min", 0, 0);

        // Simultaneous presses cancel; two presses accumulate into one update
        do_reset();
        iBtnUp = 1; iBtnDown = 1; step(8);
        iBtnUp = 0; iBtnDown = 0; step(8);
        boundary("both", 0, 0);
        press_up();
        press_up();
        boundary("accum", 50, 1);
        boundary("accum_again", 50, 0);

        // Reset during debounce discards the pending press
        do_reset();
        press_up(); press_up(); press_up();
        boundary("pre_rst", 75, 1);
        iBtnUp = 1; step(3);
        iRst_n = 0; iBtnUp = 0;
        #1;
        chk("async_rst_duty", int'(oDuty), INIT);
        step(2);
        iRst_n = 1;
        step(10);
        boundary("post_rst", 0, 0);

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) iBtnUp = ~iBtnUp;
            if ($urandom_range(0, 9) == 0) iBtnDown = ~iBtnDown;
            iPeriodEnd = ($urandom_range(0, 7) == 0);
            iRst_n = ($urandom_range(0, 999) != 0);
            step(1);
        end
        iRst_n = 1; iPeriodEnd = 0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
